// File: rtl/serial_adder_pkg.sv
// Shared types and configuration checks for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width is in range and splits into whole digits.
  function automatic bit cfg_legal(input int width, input int digit);
    return (width >= 2) && (width <= 64) && (digit >= 1) &&
           (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/full_adder_dataflow.sv
// One-bit full adder cell, chained to form each digit of the serial adder.
module full_adder_dataflow (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle, WIDTH/DIGIT cycles per operation.
// Optional subtract mode (port sub) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!cfg_legal(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be 2..64 and a multiple of DIGIT");
  end

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; busy is
  // high for exactly N cycles, then done pulses for one cycle with sum/cout/ovf
  // valid, and those outputs hold until the next done.
  state_t           state, state_nx;
  logic             load;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             unused_bits;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the carry-in port is ignored in that mode.
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_digit
    full_adder_dataflow u_fa (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .cin  (c[i]),
      .sum  (dsum[i]),
      .cout (c[i+1])
    );
  end

  // New digit enters at the MSB end; after N shifts the result is aligned.
  assign res_cat     = {dsum, res_q};
  assign res_nx      = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign unused_bits = ^res_cat[DIGIT-1:0];
  assign last        = (cnt_q == CW'(N - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          state_nx = RUN;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b_ld;
      res_q   <= '0;
      carry_q <= c_ld;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_nx;
      carry_q <= c[DIGIT];
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        sum  <= res_nx;
        cout <= c[DIGIT];
        ovf  <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values 2..64.
REQ-002 SHALL have parameter DIGIT, default 1, meaning bits added per cycle; WIDTH SHALL be a multiple of DIGIT (elaboration error otherwise).
REQ-003 SHALL have clock port clk, input, 1 bit; all state updates on its rising edge.
REQ-004 SHALL have reset port rst_n, input, 1 bit; asynchronous, active-low.
REQ-005 SHALL have start, input, 1 bit, meaning request an addition.
REQ-006 SHALL have a and b, inputs, WIDTH bits each, meaning operands sampled with start.
REQ-007 SHALL have cin, input, 1 bit, meaning carry-in sampled with start.
REQ-008 SHALL have busy, output, 1 bit, meaning an operation is in progress.
REQ-009 SHALL have done, output, 1 bit, meaning a one-cycle pulse marking a valid result.
REQ-010 SHALL have sum, output, WIDTH bits, meaning the result.
REQ-011 SHALL have cout, output, 1 bit, meaning the carry out of the MSB.
REQ-012 SHALL have ovf, output, 1 bit, meaning signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-014 In IDLE or DONE, start=1 SHALL load a, b and cin into internal registers, clear the digit counter, and enter RUN.
REQ-015 In RUN, each cycle SHALL add the DIGIT LSBs of the operand registers plus the carry register, shift the result digit into the result register from the MSB end, shift the operands right by DIGIT, and register the carry.
REQ-016 RUN SHALL last exactly N cycles, after which the FSM SHALL enter DONE; DONE SHALL last one cycle and then return to IDLE unless start=1.
REQ-017 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-018 done SHALL rise exactly N+1 rising edges after the edge that samples start.
REQ-019 sum, cout and ovf SHALL update only on entry to DONE and SHALL hold until the next entry to DONE; they SHALL NOT change during RUN.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-021 start=1 in DONE SHALL be accepted; done pulses and busy rises on the same edge, giving back-to-back operations.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; {cout,sum} SHALL equal a+b+cin exactly.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, sum=0, cout=0, ovf=0, and clear all internal registers.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL behave as from power-up.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN defined: port sub (input, 1 bit, sampled with start) SHALL be present; sub=1 SHALL compute a + ~b + 1, ignoring cin, and cout=1 SHALL mean no borrow.
REQ-026 SERIAL_ADDER_SUB_EN undefined: port sub SHALL be absent and only addition SHALL be available.

Structure
REQ-027 Package serial_adder_pkg SHALL hold the FSM state enum typedef and the WIDTH/DIGIT legality-check function.
REQ-028 Each digit SHALL be built from a DIGIT-long chain of the existing one-bit cell full_adder_dataflow (a, b, cin -> sum, cout); no other sub-module.

Verification
REQ-029 WIDTH=8, DIGIT=1, a=0xFF, b=0x01, cin=0, start pulse -> busy high for 8 cycles, done 9 edges after start, sum=0x00, cout=1, ovf=0.
REQ-030 WIDTH=8, DIGIT=4, a=0x7F, b=0x01, cin=0 -> done 3 edges after start, sum=0x80, cout=0, ovf=1.
REQ-031 WIDTH=8, DIGIT=1, start at cycle 0 with a=0x10, b=0x20; start again at cycle 3 with a=0xFF -> result 0x30 only, single done pulse.
REQ-032 start in the DONE cycle with a=0x01, b=0x01, cin=1 -> previous result pulses done; next result sum=0x03 after a further N+1 edges.
REQ-033 rst_n low at cycle 4 of RUN -> all outputs 0 immediately, no done; new start after release -> correct result.
REQ-034 SERIAL_ADDER_SUB_EN defined, WIDTH=8, a=5, b=7, sub=1 -> sum=0xFE, cout=0; a=7, b=5 -> sum=0x02, cout=1.
